// File: rtl/apb_pkg.sv
// apb_pkg: shared types for the APB burst sequencer.
// Transfer sizes, sequencer states and timing defaults.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_pkg;

  typedef enum logic [1:0] {
    FULLWORD = 2'd0,
    HALFWORD = 2'd1,
    BYTE     = 2'd2
  } dsel_type;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_REQ,
    S_GAP,
    S_DONE
  } seq_state_t;

  localparam int         TIMEOUT_DEF  = 64;
  localparam logic [1:0] DSEL_ILLEGAL = 2'd3;

  function automatic logic [2:0] size_incr(input logic [1:0] dsel);
    case (dsel)
      FULLWORD: size_incr = 3'd4;
      HALFWORD: size_incr = 3'd2;
      BYTE:     size_incr = 3'd1;
      default:  size_incr = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/apb_seq_timeout.sv
// apb_seq_timeout: loadable down-counter bounding how long a
// single beat may wait on the bridge; flags expiry at zero.
module apb_seq_timeout #(
  parameter int CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = (CYC > 1) ? $clog2(CYC) : 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= W'(CYC - 1);
    else if (i_en && r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/apb_burst_sequencer.sv
// apb_burst_sequencer: expands burst commands into single-beat
// requests for apb_bridge, with per-beat timeout and error count.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_burst_sequencer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = `ADDR_WIDTH,
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int CNT_WIDTH   = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [1:0]            cmd_dsel,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_err,
  output logic                  br_trnsfr,
  output logic                  br_wr,
  output logic [1:0]            br_dsel,
  output logic [ADDR_WIDTH-1:0] br_address,
  output logic [DATA_WIDTH-1:0] br_data_in,
  input  logic [DATA_WIDTH-1:0] br_data_out,
  input  logic                  br_ready,
  input  logic                  br_slverr,
  output logic                  done,
  output logic [CNT_WIDTH:0]    err_cnt
);

  localparam logic [CNT_WIDTH:0] ERR_MAX =
    {1'b1, {CNT_WIDTH{1'b0}}};

  seq_state_t r_state, w_next;

  logic                  r_wr;
  logic [1:0]            r_dsel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_rerr;
  logic [CNT_WIDTH:0]    r_beats;
  logic [CNT_WIDTH:0]    r_err;

  logic               w_stall;
  logic               w_tmo_load;
  logic               w_expire;
  logic               w_beat_end;
  logic               w_beat_err;
  logic [CNT_WIDTH:0] w_cmd_beats;
  logic [CNT_WIDTH:0] w_err_inc;

  // count 0 stands for a full 2^CNT_WIDTH-beat burst
  assign w_cmd_beats = {cmd_count == '0, cmd_count};
  assign w_stall     = r_rvalid && !rdata_ready;
  assign w_beat_end  = br_ready || w_expire;
  assign w_beat_err  = br_ready ? br_slverr : 1'b1;
  assign w_err_inc   = (r_err == ERR_MAX) ? r_err : r_err + 1'b1;

  apb_seq_timeout #(
    .CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_tmo_load),
    .i_en     (r_state == S_REQ),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    br_trnsfr   = 1'b0;
    done        = 1'b0;
    w_tmo_load  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_dsel == DSEL_ILLEGAL) begin
            w_next = S_DONE;
          end else if (cmd_wr) begin
            w_next = S_WDATA;
          end else begin
            w_next     = S_REQ;
            w_tmo_load = 1'b1;
          end
        end
      end
      S_WDATA: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          w_next     = S_REQ;
          w_tmo_load = 1'b1;
        end
      end
      S_REQ: begin
        br_trnsfr = 1'b1;
        if (w_beat_end) w_next = S_GAP;
      end
      S_GAP: begin
        if (!w_stall) begin
          if (r_beats == 1) begin
            w_next = S_DONE;
          end else if (r_wr) begin
            w_next = S_WDATA;
          end else begin
            w_next     = S_REQ;
            w_tmo_load = 1'b1;
          end
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr     <= 1'b0;
      r_dsel   <= 2'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_beats  <= '0;
      r_err    <= '0;
    end else begin
      if (r_rvalid && rdata_ready) r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_beats <= w_cmd_beats;
            if (cmd_dsel == DSEL_ILLEGAL) begin
              r_err <= w_cmd_beats;
            end else begin
              r_err  <= '0;
              r_wr   <= cmd_wr;
              r_dsel <= cmd_dsel;
              r_addr <= cmd_addr;
            end
          end
        end
        S_WDATA: begin
          if (wdata_valid) r_wdata <= wdata;
        end
        S_REQ: begin
          if (w_beat_end) begin
            if (w_beat_err) r_err <= w_err_inc;
            if (!r_wr) begin
              r_rvalid <= 1'b1;
              r_rerr   <= w_beat_err;
              r_rdata  <= br_ready ? br_data_out : '0;
            end
          end
        end
        S_GAP: begin
          if (!w_stall) begin
            r_beats <= r_beats - 1'b1;
            r_addr  <= r_addr + ADDR_WIDTH'(size_incr(r_dsel));
          end
        end
        default: ;
      endcase
    end
  end

  assign br_wr       = r_wr;
  assign br_dsel     = r_dsel;
  assign br_address  = r_addr;
  assign br_data_in  = r_wdata;
  assign rdata_valid = r_rvalid;
  assign rdata       = r_rdata;
  assign rdata_err   = r_rerr;
  assign err_cnt     = r_err;

endmodule

// File: tb/tb_apb_burst_sequencer.sv
// Randomised bench for apb_burst_sequencer: bridge and stream
// models drive the DUT and check against a burst-level model.
module tb_apb_burst_sequencer;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [1:0]    cmd_dsel;
  logic [AW-1:0] cmd_addr;
  logic [CW-1:0] cmd_count;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid, rdata_ready, rdata_err;
  logic [DW-1:0] rdata;
  logic          br_trnsfr, br_wr;
  logic [1:0]    br_dsel;
  logic [AW-1:0] br_address;
  logic [DW-1:0] br_data_in, br_data_out;
  logic          br_ready, br_slverr;
  logic          done;
  logic [CW:0]   err_cnt;

  always #5 clk = ~clk;

  apb_burst_sequencer #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .CNT_WIDTH   (CW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr      (cmd_wr),
    .cmd_dsel    (cmd_dsel),
    .cmd_addr    (cmd_addr),
    .cmd_count   (cmd_count),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .rdata_err   (rdata_err),
    .br_trnsfr   (br_trnsfr),
    .br_wr       (br_wr),
    .br_dsel     (br_dsel),
    .br_address  (br_address),
    .br_data_in  (br_data_in),
    .br_data_out (br_data_out),
    .br_ready    (br_ready),
    .br_slverr   (br_slverr),
    .done        (done),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [1:0]    dsel;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
  } rsp_t;

  beat_t         exp_q[$];
  rsp_t          rsp_q[$];
  logic [DW-1:0] wq[$];

  int    errs = 0;
  int    checks = 0;
  int    nbeat, age, delay, mode, stall_cnt, done_cnt, exp_err;
  bit    stall_req, responded, prev_tr, have_cur, env_on;
  beat_t cur;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: random latency/errors, 1: never answer,
  // 2: always slverr, 3: fast and clean
  function automatic int pick_delay(input int md);
    int r;
    case (md)
      0: begin
        r = $urandom_range(0, 15);
        pick_delay = (r == 0) ? TMO : 1 + (r % 4);
      end
      1:       pick_delay = 0;
      default: pick_delay = $urandom_range(1, 3);
    endcase
  endfunction

  task automatic step();
    rsp_t rs;
    @(negedge clk);
    br_ready    = 1'b0;
    br_slverr   = 1'b0;
    wdata_valid = 1'b0;
    rdata_ready = 1'b0;
    if (env_on) begin
      if (done) begin
        done_cnt++;
        chk("err_cnt", err_cnt, exp_err);
      end
      if (br_trnsfr) begin
        if (!prev_tr) begin
          nbeat++;
          age       = 0;
          responded = 0;
          delay     = pick_delay(mode);
          have_cur  = (exp_q.size() > 0);
          if (have_cur) cur = exp_q.pop_front();
          chk("beat_expected", have_cur, 1);
        end
        if (have_cur) begin
          chk("br_address", br_address, cur.addr);
          chk("br_wr", br_wr, cur.wr);
          chk("br_dsel", br_dsel, cur.dsel);
          if (cur.wr) chk("br_data_in", br_data_in, cur.data);
        end
        age++;
        if (delay != 0 && age == delay) begin
          br_ready    = 1'b1;
          br_slverr   = (mode == 2) ||
                        (mode == 0 && $urandom_range(0, 3) == 0);
          br_data_out = $urandom;
          responded   = 1;
          if (br_slverr) exp_err++;
          if (have_cur && !cur.wr) begin
            rs.d = br_data_out;
            rs.e = br_slverr;
            rsp_q.push_back(rs);
          end
        end
      end else begin
        if (prev_tr) begin
          chk("trnsfr_cycles", age, responded ? delay : TMO);
          if (!responded) begin
            exp_err++;
            if (have_cur && !cur.wr) begin
              rs.d = '0;
              rs.e = 1'b1;
              rsp_q.push_back(rs);
            end
          end
        end
        if ($urandom_range(0, 7) == 0) begin
          br_ready    = 1'b1;
          br_slverr   = 1'b1;
          br_data_out = $urandom;
        end
      end
      if (wq.size() > 0) begin
        wdata       = wq[0];
        wdata_valid = ($urandom_range(0, 3) != 0);
        if (wdata_valid && wdata_ready) wq.delete(0);
      end
      if (stall_req && rdata_valid && nbeat >= 3) begin
        stall_req = 0;
        stall_cnt = 10;
      end
      if (stall_cnt > 0) begin
        stall_cnt--;
        chk("stall_trnsfr", br_trnsfr, 0);
        chk("stall_rvalid", rdata_valid, 1);
      end else begin
        rdata_ready = ($urandom_range(0, 3) != 0);
      end
      if (rdata_valid && rdata_ready) begin
        chk("rdata_expected", rsp_q.size() > 0, 1);
        if (rsp_q.size() > 0) begin
          rs = rsp_q.pop_front();
          chk("rdata", rdata, rs.d);
          chk("rdata_err", rdata_err, rs.e);
        end
      end
    end
    prev_tr = br_trnsfr;
  endtask

  task automatic arm(input logic wr, input logic [1:0] dsel,
                     input logic [AW-1:0] addr, input logic [CW-1:0] cnt,
                     input int md, input bit stl, input bit seq,
                     input logic [DW-1:0] wbase);
    beat_t b;
    int n, inc;
    n   = (cnt == 0) ? (1 << CW) : int'(cnt);
    inc = (dsel == 2'd0) ? 4 : (dsel == 2'd1) ? 2 : 1;
    exp_q.delete();
    rsp_q.delete();
    wq.delete();
    nbeat = 0; done_cnt = 0; exp_err = 0;
    mode  = md; stall_req = stl;
    for (int i = 0; i < n; i++) begin
      b.addr = addr + AW'(i * inc);
      b.wr   = wr;
      b.dsel = dsel;
      b.data = seq ? wbase + DW'(i) : DW'($urandom);
      if (wr) wq.push_back(b.data);
      if (dsel != 2'd3) exp_q.push_back(b);
    end
    if (dsel == 2'd3) exp_err = n;
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_dsel  = dsel;
    cmd_addr  = addr;
    cmd_count = cnt;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_count = CW'($urandom);
  endtask

  task automatic run_burst(input logic wr, input logic [1:0] dsel,
                           input logic [AW-1:0] addr,
                           input logic [CW-1:0] cnt, input int md,
                           input bit stl, input bit seq,
                           input logic [DW-1:0] wbase);
    int n, keep;
    n    = (cnt == 0) ? (1 << CW) : int'(cnt);
    keep = (dsel == 2'd3 && wr) ? n : 0;
    arm(wr, dsel, addr, cnt, md, stl, seq, wbase);
    for (int c = 0; c < n * 80 + 40 && done_cnt == 0; c++) step();
    chk("done_seen", done_cnt, 1);
    chk("beats_issued", nbeat, (dsel == 2'd3) ? 0 : n);
    chk("beats_left", exp_q.size(), 0);
    chk("rdata_left", rsp_q.size(), 0);
    chk("wdata_left", wq.size(), keep);
    step();
    chk("done_single", done_cnt, 1);
    chk("ready_after_done", cmd_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_br_address"}, br_address, 0);
    chk({tag, "_br_data_in"}, br_data_in, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_ctl"}, {br_trnsfr, br_wr, br_dsel, rdata_valid,
                        rdata_err, done, wdata_ready}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_dsel = 2'd0;
    cmd_addr = '0; cmd_count = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    br_data_out = '0; br_ready = 1'b0; br_slverr = 1'b0;
    env_on = 0; prev_tr = 0; stall_cnt = 0; stall_req = 0;
    mode = 3; nbeat = 0; done_cnt = 0; exp_err = 0;
    step();
    step();
    rst = 1'b0;
    step();
    chk_reset_outputs("reset");
    env_on = 1;

    run_burst(1'b0, 2'd0, 32'h1100_00B0, 8'd8, 3, 0, 0, '0);
    run_burst(1'b1, 2'd1, 32'h1100_0050, 8'd4, 3, 0, 1, 32'h3187_EFC6);
    run_burst(1'b0, 2'd2, 32'h1100_0400, 8'd4, 2, 0, 0, '0);
    run_burst(1'b0, 2'd0, 32'h1100_0A00, 8'd2, 1, 0, 0, '0);
    run_burst(1'b0, 2'd0, 32'h1100_0800, 8'd6, 3, 1, 0, '0);
    chk("stall_applied", stall_req, 0);
    run_burst(1'b1, 2'd3, 32'h1100_0900, 8'd5, 3, 0, 0, '0);
    run_burst(1'b0, 2'd3, 32'h1100_0900, 8'd0, 3, 0, 0, '0);
    for (int k = 0; k < 6; k++)
      run_burst(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                $urandom, 8'($urandom_range(1, 12)), 0, 0, 0, '0);
    run_burst(1'b0, 2'd0, 32'hFFFF_FF80, 8'd0, 3, 0, 0, '0);

    arm(1'b1, 2'd0, 32'h3000_0040, 8'd8, 3, 0, 0, '0);
    for (int c = 0; c < 400 && nbeat < 3; c++) step();
    chk("reached_beat3", nbeat, 3);
    env_on    = 0;
    rst       = 1'b1;
    br_ready  = 1'b0;
    br_slverr = 1'b0;
    step();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    for (int c = 0; c < 8; c++) begin
      step();
      chk("midrst_no_done", done, 0);
      chk("midrst_no_trnsfr", br_trnsfr, 0);
      chk("midrst_no_wready", wdata_ready, 0);
    end
    env_on = 1;
    run_burst(1'b0, 2'd1, 32'h1100_0C00, 8'd3, 3, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
